loop_address_sequencer: RTL and testbench

- Walks a two-level loop nest (outer × inner) and issues one flat address per iteration on a valid/ready stream.
- Keeps both subscripts as stride accumulators and feeds them to the existing flat-address adder (flat_address_gen) together with a loop-invariant constant.
- Sits between the access-unit configuration registers and the memory-request port of a processing element; one instance per access stream.

---
 rtl/mage_pkg.sv | 13 +
 rtl/flat_address_gen.sv | 18 +
 rtl/loop_address_sequencer.sv | 127 ++++++++++++
 tb/tb_loop_address_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mage_pkg.sv
// Shared widths and types for the memory access generation blocks.
package mage_pkg;

  localparam int unsigned N_SUBSCRIPTS      = 2;
  localparam int unsigned NBIT_FLAT_ADDR    = 16;
  localparam int unsigned NBIT_IV_CONST     = 8;
  localparam int unsigned NBIT_LOOP_DEFAULT = 8;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_DONE} seq_state_t;

  typedef logic [N_SUBSCRIPTS-1:0][NBIT_FLAT_ADDR-1:0] subscript_vec_t;

endpackage

// File: rtl/flat_address_gen.sv
// Flat address = sum of all subscripts plus the zero-extended loop-invariant constant.
module flat_address_gen
  import mage_pkg::*;
(
  input  subscript_vec_t             subscripts_i,
  input  logic [NBIT_IV_CONST-1:0]   iv_const_i,
  output logic [NBIT_FLAT_ADDR-1:0]  flat_addr_o
);

  // Modulo-2^NBIT_FLAT_ADDR accumulation; carries out of the top bit are dropped.
  always_comb begin
    flat_addr_o = NBIT_FLAT_ADDR'(iv_const_i);
    for (int unsigned i = 0; i < N_SUBSCRIPTS; i++) begin
      flat_addr_o = flat_addr_o + subscripts_i[i];
    end
  end

endmodule

// File: rtl/loop_address_sequencer.sv
// Walks an outer x inner loop nest and streams one flat address per iteration
// over a valid/ready interface.
module loop_address_sequencer
  import mage_pkg::*;
#(
  parameter int unsigned NBIT_LOOP = NBIT_LOOP_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [NBIT_LOOP-1:0]       n_inner_i,
  input  logic [NBIT_LOOP-1:0]       n_outer_i,
  input  subscript_vec_t             stride_i,
  input  logic [NBIT_IV_CONST-1:0]   iv_const_i,
  output logic [NBIT_FLAT_ADDR-1:0]  addr_o,
  output logic                       addr_valid_o,
  input  logic                       addr_ready_i,
  output logic                       last_o,
  output logic                       busy_o,
  output logic                       done_o
);

  seq_state_t                 state_q, state_d;
  logic [NBIT_LOOP-1:0]       n_inner_q, n_outer_q;
  logic [NBIT_LOOP-1:0]       inner_cnt_q, outer_cnt_q;
  subscript_vec_t             stride_q;
  subscript_vec_t             sub_q;
  logic [NBIT_IV_CONST-1:0]   iv_const_q;

  logic start_ok_c;
  logic zero_trip_c;
  logic inner_end_c;
  logic outer_end_c;
  logic handshake_c;

  assign start_ok_c  = (state_q == SEQ_IDLE) && start_i;
  assign zero_trip_c = (n_inner_i == '0) || (n_outer_i == '0);
  assign inner_end_c = (inner_cnt_q == n_inner_q - NBIT_LOOP'(1));
  assign outer_end_c = (outer_cnt_q == n_outer_q - NBIT_LOOP'(1));
  assign handshake_c = (state_q == SEQ_RUN) && addr_ready_i;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; abort outranks completion of the final handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEQ_IDLE: begin
        if (start_i) begin
          state_d = zero_trip_c ? SEQ_DONE : SEQ_RUN;
        end
      end
      SEQ_RUN: begin
        if (abort_i) begin
          state_d = SEQ_IDLE;
        end else if (handshake_c && inner_end_c && outer_end_c) begin
          state_d = SEQ_DONE;
        end
      end
      SEQ_DONE: state_d = SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    addr_valid_o = 1'b0;
    last_o       = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    unique case (state_q)
      SEQ_IDLE: busy_o = 1'b0;
      SEQ_RUN: begin
        addr_valid_o = 1'b1;
        last_o       = inner_end_c && outer_end_c;
      end
      SEQ_DONE: done_o = 1'b1;
      default:  busy_o = 1'b0;
    endcase
  end

  // Configuration latch, iteration counters and stride accumulators.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      n_inner_q   <= '0;
      n_outer_q   <= '0;
      stride_q    <= '0;
      iv_const_q  <= '0;
      inner_cnt_q <= '0;
      outer_cnt_q <= '0;
      sub_q       <= '0;
    end else if (start_ok_c) begin
      n_inner_q   <= n_inner_i;
      n_outer_q   <= n_outer_i;
      stride_q    <= stride_i;
      iv_const_q  <= iv_const_i;
      inner_cnt_q <= '0;
      outer_cnt_q <= '0;
      sub_q       <= '0;
    end else if (handshake_c && !(inner_end_c && outer_end_c)) begin
      if (inner_end_c) begin
        inner_cnt_q <= '0;
        sub_q[0]    <= '0;
        outer_cnt_q <= outer_cnt_q + NBIT_LOOP'(1);
        sub_q[1]    <= sub_q[1] + stride_q[1];
      end else begin
        inner_cnt_q <= inner_cnt_q + NBIT_LOOP'(1);
        sub_q[0]    <= sub_q[0] + stride_q[0];
      end
    end
  end

  flat_address_gen u_flat_address_gen (
    .subscripts_i (sub_q),
    .iv_const_i   (iv_const_q),
    .flat_addr_o  (addr_o)
  );

endmodule

// File: tb/tb_loop_address_sequencer.sv
// Randomized self-checking bench for loop_address_sequencer against a nested-loop address model.
module tb_loop_address_sequencer;
  import mage_pkg::*;

  logic                      clk_i = 1'b0;
  logic                      rst_n_i;
  logic                      start_i;
  logic                      abort_i;
  logic [7:0]                n_inner_i;
  logic [7:0]                n_outer_i;
  subscript_vec_t            stride_i;
  logic [NBIT_IV_CONST-1:0]  iv_const_i;
  logic [NBIT_FLAT_ADDR-1:0] addr_o;
  logic                      addr_valid_o;
  logic                      addr_ready_i;
  logic                      last_o;
  logic                      busy_o;
  logic                      done_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  loop_address_sequencer #(.NBIT_LOOP(8)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .n_inner_i    (n_inner_i),
    .n_outer_i    (n_outer_i),
    .stride_i     (stride_i),
    .iv_const_i   (iv_const_i),
    .addr_o       (addr_o),
    .addr_valid_o (addr_valid_o),
    .addr_ready_i (addr_ready_i),
    .last_o       (last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic scramble_cfg();
    n_inner_i  = 8'($urandom);
    n_outer_i  = 8'($urandom);
    stride_i   = subscript_vec_t'({16'($urandom), 16'($urandom)});
    iv_const_i = 8'($urandom);
  endtask

  // rdy_pct < 0 selects the fixed ready pattern 1,0,0,1,0,0...
  // abort_hs > 0 aborts on that handshake number; probe raises a stray start at the 2nd address.
  task automatic run_seq(input logic [7:0] ni, input logic [7:0] no,
                         input logic [15:0] s0, input logic [15:0] s1,
                         input logic [7:0] iv, input int rdy_pct,
                         input int abort_hs, input bit probe);
    logic [15:0] exp_q[$];
    logic [15:0] prev_addr;
    logic        prev_last;
    bit          stalled = 0;
    bit          aborted = 0;
    bit          probed  = 0;
    bit          fin     = 0;
    int          hs = 0;
    int          done_seen = 0;
    int          valid_seen = 0;
    int          last_hs_cyc = -1;
    int          cyc = 0;

    for (int o = 0; o < int'(no); o++)
      for (int i = 0; i < int'(ni); i++)
        exp_q.push_back(16'(i * int'(s0) + o * int'(s1) + int'(iv)));

    start_i    = 1'b1;
    n_inner_i  = ni;
    n_outer_i  = no;
    stride_i   = subscript_vec_t'({s1, s0});
    iv_const_i = iv;
    @(negedge clk_i);

    while (!fin && cyc < 2000) begin
      start_i = 1'b0;
      abort_i = 1'b0;
      scramble_cfg();
      if (rdy_pct < 0) addr_ready_i = (cyc % 3 == 0);
      else             addr_ready_i = ($urandom_range(99) < rdy_pct);

      if (!busy_o) begin
        check_eq("idle_valid", {31'd0, addr_valid_o}, 32'd0);
        fin = 1;
      end else begin
        if (rdy_pct >= 100 && hs < exp_q.size())
          check_eq("valid_run", {31'd0, addr_valid_o}, 32'd1);
        if (addr_valid_o) begin
          valid_seen++;
          if (stalled) begin
            check_eq("stall_addr", {16'd0, addr_o}, {16'd0, prev_addr});
            check_eq("stall_last", {31'd0, last_o}, {31'd0, prev_last});
          end
          if (hs < exp_q.size()) begin
            check_eq("addr", {16'd0, addr_o}, {16'd0, exp_q[hs]});
            check_eq("last", {31'd0, last_o}, {31'd0, (hs == exp_q.size() - 1)});
          end else begin
            check_eq("extra_valid", {31'd0, addr_valid_o}, 32'd0);
          end
          if (probe && !probed && hs == 1) begin
            start_i = 1'b1;
            probed  = 1;
          end
          if (addr_ready_i) begin
            hs++;
            stalled = 0;
            if (hs == exp_q.size()) last_hs_cyc = cyc;
            if (abort_hs == hs) begin
              abort_i = 1'b1;
              aborted = 1;
            end
          end else begin
            stalled   = 1;
            prev_addr = addr_o;
            prev_last = last_o;
          end
        end
        if (done_o) begin
          done_seen++;
          if (exp_q.size() > 0) check_eq("done_lat", 32'(cyc), 32'(last_hs_cyc + 1));
          else                  check_eq("zero_done_lat", 32'(cyc), 32'd0);
        end
      end
      @(negedge clk_i);
      cyc++;
    end

    start_i = 1'b0;
    abort_i = 1'b0;
    addr_ready_i = 1'b0;
    if (!fin) check_eq("timeout", 32'd1, 32'd0);
    check_eq("hs_count", 32'(hs), aborted ? 32'(abort_hs) : 32'(exp_q.size()));
    check_eq("done_count", 32'(done_seen), aborted ? 32'd0 : 32'd1);
    if (exp_q.size() == 0) check_eq("zero_valid", 32'(valid_seen), 32'd0);
    check_eq("end_busy", {31'd0, busy_o}, 32'd0);
  endtask

  // Asynchronous reset asserted while the third address is on the bus.
  task automatic reset_midrun();
    start_i = 1'b1; n_inner_i = 8'd3; n_outer_i = 8'd2;
    stride_i = subscript_vec_t'({16'd4, 16'd1}); iv_const_i = 8'd16;
    addr_ready_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check_eq("rst_pre_addr", {16'd0, addr_o}, 32'd18);
    #2 rst_n_i = 1'b0;
    #1;
    check_eq("rst_addr", {16'd0, addr_o}, 32'd0);
    check_eq("rst_valid", {31'd0, addr_valid_o}, 32'd0);
    check_eq("rst_last", {31'd0, last_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check_eq("post_rst_busy", {31'd0, busy_o}, 32'd0);
      check_eq("post_rst_valid", {31'd0, addr_valid_o}, 32'd0);
    end
    addr_ready_i = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0;
    start_i = 1'b0;
    abort_i = 1'b0;
    addr_ready_i = 1'b0;
    scramble_cfg();
    repeat (2) @(negedge clk_i);
    check_eq("reset_addr", {16'd0, addr_o}, 32'd0);
    check_eq("reset_valid", {31'd0, addr_valid_o}, 32'd0);
    check_eq("reset_last", {31'd0, last_o}, 32'd0);
    check_eq("reset_busy", {31'd0, busy_o}, 32'd0);
    check_eq("reset_done", {31'd0, done_o}, 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    abort_i = 1'b1;
    @(negedge clk_i);
    abort_i = 1'b0;
    check_eq("idle_abort_busy", {31'd0, busy_o}, 32'd0);

    run_seq(8'd3, 8'd2, 16'd1, 16'd4, 8'd16, 100, 0, 0);
    run_seq(8'd3, 8'd2, 16'd1, 16'd4, 8'd16, -1, 0, 0);
    run_seq(8'd0, 8'd5, 16'd1, 16'd4, 8'd16, 100, 0, 0);
    run_seq(8'd4, 8'd0, 16'd1, 16'd4, 8'd16, 100, 0, 0);
    run_seq(8'd3, 8'd1, 16'hFFFF, 16'd0, 8'd5, 100, 0, 0);
    run_seq(8'd3, 8'd2, 16'd1, 16'd4, 8'd16, 100, 4, 1);
    run_seq(8'd3, 8'd2, 16'd1, 16'd4, 8'd16, 100, 0, 0);
    run_seq(8'd2, 8'd2, 16'd3, 16'd7, 8'd1, 100, 4, 0);

    abort_i = 1'b1;
    run_seq(8'd2, 8'd1, 16'd9, 16'd0, 8'd2, 100, 0, 0);

    for (int t = 0; t < 25; t++) begin
      logic [7:0]  ni, no, iv;
      logic [15:0] s0, s1;
      int          ab, total;
      ni = 8'($urandom_range(6));
      no = 8'($urandom_range(5));
      s0 = 16'($urandom);
      s1 = 16'($urandom);
      iv = 8'($urandom);
      total = int'(ni) * int'(no);
      ab = (total > 0 && $urandom_range(3) == 0) ? int'($urandom_range(total, 1)) : 0;
      run_seq(ni, no, s0, s1, iv, int'($urandom_range(100, 30)), ab, $urandom_range(1) == 1);
      repeat ($urandom_range(2)) @(negedge clk_i);
    end

    reset_midrun();
    run_seq(8'd2, 8'd3, 16'd5, 16'd100, 8'd7, 70, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
